hilo_mult_unit: RTL and testbench

//  Multi-cycle HI/LO multiply unit, downstream of the ALU controller. Consumes the
//  5-bit ALUControl code for multiply-class ops plus operands A/B from the register

---
 rtl/hilo_mult_unit_pkg.sv | 22 ++
 rtl/hilo_mult_unit_shift_add.sv | 46 ++++
 rtl/hilo_mult_unit.sv | 113 +++++++++++
 tb/tb_hilo_mult_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_mult_unit_pkg.sv
// Shared definitions for the HI/LO multiply unit: ALUControl op codes and FSM state encoding.
package hilo_mult_unit_pkg;

    localparam logic [4:0] ALU_MULT  = 5'd16;
    localparam logic [4:0] ALU_MULTU = 5'd17;
    localparam logic [4:0] ALU_MADD  = 5'd18;
    localparam logic [4:0] ALU_MSUB  = 5'd19;
    localparam logic [4:0] ALU_MTHI  = 5'd20;
    localparam logic [4:0] ALU_MTLO  = 5'd21;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_ACC  = 2'b10
    } state_t;

    // Ops that run through the iterative shift-add core.
    function automatic logic is_mult_op(input logic [4:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_MADD) || (op == ALU_MSUB);
    endfunction

endpackage

// File: rtl/hilo_mult_unit_shift_add.sv
// Iterative unsigned shift-add multiplier core: one multiplier bit per step, WIDTH steps.
module hilo_mult_unit_shift_add #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic [2*WIDTH-1:0] acc,
    output logic               last
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] a_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [CW-1:0]      count_reg;

    // The multiplicand is shifted left each step, equivalent to adding A << counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            count_reg <= '0;
        end else if (load) begin
            a_reg     <= {{WIDTH{1'b0}}, a_in};
            b_reg     <= b_in;
            acc_reg   <= '0;
            count_reg <= '0;
        end else if (step) begin
            if (b_reg[0]) begin
                acc_reg <= acc_reg + a_reg;
            end
            a_reg     <= a_reg << 1;
            b_reg     <= b_reg >> 1;
            count_reg <= count_reg + 1'b1;
        end
    end

    assign acc  = acc_reg;
    assign last = (count_reg == CW'(WIDTH - 1));

endmodule

// File: rtl/hilo_mult_unit.sv
// Multi-cycle HI/LO multiply unit: MULT/MULTU/MADD/MSUB via shift-add core, plus MTHI/MTLO.
module hilo_mult_unit
    import hilo_mult_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    state_t             state_reg;
    logic [4:0]         op_reg;
    logic               neg_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;

    logic               signed_op;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] hilo_next;
    logic               load;
    logic               step;
    logic               last;

    assign load = (state_reg == ST_IDLE) && start && is_mult_op(alu_control);
    assign step = (state_reg == ST_MUL);

    // Magnitude of the most negative value wraps to itself, which is the correct unsigned 2^(W-1).
    always_comb begin
        signed_op = (alu_control != ALU_MULTU);
        mag_a     = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
        mag_b     = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
        product   = neg_reg ? (~acc + 1'b1) : acc;
        case (op_reg)
            ALU_MADD: hilo_next = {hi_reg, lo_reg} + product;
            ALU_MSUB: hilo_next = {hi_reg, lo_reg} - product;
            default:  hilo_next = product;
        endcase
    end

    hilo_mult_unit_shift_add #(.WIDTH(WIDTH)) u_core (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .a_in (mag_a),
        .b_in (mag_b),
        .acc  (acc),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            op_reg    <= '0;
            neg_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (alu_control == ALU_MTHI) begin
                            hi_reg <= a;
                        end else if (alu_control == ALU_MTLO) begin
                            lo_reg <= a;
                        end else if (is_mult_op(alu_control)) begin
                            op_reg    <= alu_control;
                            neg_reg   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                            busy_reg  <= 1'b1;
                            state_reg <= ST_MUL;
                        end
                    end
                end
                ST_MUL: begin
                    if (last) begin
                        state_reg <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    {hi_reg, lo_reg} <= hilo_next;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed self-checking bench for hilo_mult_unit; one line per transaction.
module tb_hilo_mult_unit;
    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  alu_control;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    localparam logic [4:0] OP_MULT  = 5'd16;
    localparam logic [4:0] OP_MULTU = 5'd17;
    localparam logic [4:0] OP_MADD  = 5'd18;
    localparam logic [4:0] OP_MSUB  = 5'd19;
    localparam logic [4:0] OP_MTHI  = 5'd20;
    localparam logic [4:0] OP_MTLO  = 5'd21;

    hilo_mult_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .alu_control (alu_control),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one rising edge, then scramble operands; returns at the negedge after.
    task automatic do_start(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        start = 1'b1;
        alu_control = op;
        a = av;
        b = bv;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    // Counts negedges until done is seen, bounded at 40.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        alu_control = 5'd0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++;
        if ({hi, lo, busy, done} !== 66'd0) begin
            bad++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b want all zero", hi, lo, busy, done);
        end
        do_start(5'd0, 32'h1234_5678, 32'h9abc_def0);
        @(negedge clk);
        total++;
        if ({hi, lo, busy, done} !== 66'd0) begin
            bad++;
            $display("FAIL nop_code: got hi=%h lo=%h busy=%b done=%b want all zero", hi, lo, busy, done);
        end
        $display("reset/nop: hi=%h lo=%h busy=%b", hi, lo, busy);
    endtask

    task automatic test_multu;
        int cyc;
        do_start(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL multu_busy: got %b want 1", busy);
        end
        wait_done(cyc);
        total++;
        if (cyc != 33) begin
            bad++;
            $display("FAIL multu_latency: got %0d want 33", cyc);
        end
        total++;
        if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001 || busy !== 1'b0) begin
            bad++;
            $display("FAIL multu_result: got %h_%h busy=%b want fffffffe_00000001 busy=0", hi, lo, busy);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL multu_done_pulse: got %b want 0", done);
        end
        $display("MULTU ffffffff*ffffffff: hi=%h lo=%h cycles=%0d", hi, lo, cyc);
    endtask

    task automatic test_mult;
        logic [31:0] av [3];
        logic [31:0] bv [3];
        logic [63:0] ev [3];
        int cyc;
        av[0] = 32'hFFFF_FFFD; bv[0] = 32'd7;         ev[0] = 64'hFFFF_FFFF_FFFF_FFEB;
        av[1] = 32'h8000_0000; bv[1] = 32'h8000_0000; ev[1] = 64'h4000_0000_0000_0000;
        av[2] = 32'hFFFF_FFFF; bv[2] = 32'hFFFF_FFFF; ev[2] = 64'h0000_0000_0000_0001;
        for (int i = 0; i < 3; i++) begin
            do_start(OP_MULT, av[i], bv[i]);
            wait_done(cyc);
            total++;
            if ({hi, lo} !== ev[i] || cyc != 33) begin
                bad++;
                $display("FAIL mult_%0d: got %h_%h cyc=%0d want %h cyc=33", i, hi, lo, cyc, ev[i]);
            end
            $display("MULT %h*%h: hi=%h lo=%h", av[i], bv[i], hi, lo);
        end
    endtask

    task automatic test_madd_msub;
        int cyc;
        do_start(OP_MTHI, 32'h0, 32'h0);
        do_start(OP_MTLO, 32'hFFFF_FFFF, 32'h0);
        total++;
        if (hi !== 32'h0 || lo !== 32'hFFFF_FFFF || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL mthi_mtlo: got hi=%h lo=%h busy=%b done=%b want 0/ffffffff/0/0", hi, lo, busy, done);
        end
        do_start(OP_MADD, 32'd1, 32'd1);
        wait_done(cyc);
        total++;
        if ({hi, lo} !== 64'h0000_0001_0000_0000) begin
            bad++;
            $display("FAIL madd: got %h_%h want 00000001_00000000", hi, lo);
        end
        $display("MADD 1*1: hi=%h lo=%h", hi, lo);
        do_start(OP_MTHI, 32'h0, 32'h0);
        do_start(OP_MTLO, 32'h0, 32'h0);
        do_start(OP_MSUB, 32'd2, 32'd3);
        wait_done(cyc);
        total++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
            bad++;
            $display("FAIL msub: got %h_%h want ffffffff_fffffffa", hi, lo);
        end
        $display("MSUB 2*3: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_busy_and_abort;
        int cyc;
        int seen_done;
        do_start(OP_MULT, 32'hFFFF_FFFE, 32'd5);
        repeat (3) @(negedge clk);
        start = 1'b1;
        alu_control = OP_MTHI;
        a = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || hi !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL mthi_while_busy: got busy=%b hi=%h want 1/ffffffff", busy, hi);
        end
        wait_done(cyc);
        total++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF6) begin
            bad++;
            $display("FAIL mult_after_ignore: got %h_%h want ffffffff_fffffff6", hi, lo);
        end
        $display("MULT -2*5 with ignored MTHI: hi=%h lo=%h", hi, lo);
        do_start(OP_MULTU, 32'd9, 32'd9);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({hi, lo, busy, done} !== 66'd0) begin
            bad++;
            $display("FAIL abort_reset: got hi=%h lo=%h busy=%b done=%b want all zero", hi, lo, busy, done);
        end
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        total++;
        if (seen_done != 0 || {hi, lo} !== 64'd0) begin
            bad++;
            $display("FAIL abort_no_done: got done_count=%0d hilo=%h_%h want 0/0", seen_done, hi, lo);
        end
        $display("abort: hi=%h lo=%h done_count=%0d", hi, lo, seen_done);
    endtask

    task automatic test_back_to_back;
        int cyc;
        do_start(OP_MULTU, 32'd3, 32'd5);
        wait_done(cyc);
        start = 1'b1;
        alu_control = OP_MULTU;
        a = 32'd6;
        b = 32'd7;
        total++;
        if (lo !== 32'd15 || hi !== 32'd0 || done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first: got hi=%h lo=%h done=%b want 0/0000000f/1", hi, lo, done);
        end
        $display("MULTU 3*5: hi=%h lo=%h", hi, lo);
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept: got busy=%b done=%b want 1/0", busy, done);
        end
        wait_done(cyc);
        total++;
        if (lo !== 32'd42 || hi !== 32'd0 || cyc != 33) begin
            bad++;
            $display("FAIL b2b_second: got hi=%h lo=%h cyc=%0d want 0/0000002a/33", hi, lo, cyc);
        end
        $display("MULTU 6*7: hi=%h lo=%h cycles=%0d", hi, lo, cyc);
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_madd_msub();
        test_busy_and_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
